wired_bus_arbiter: RTL
======================

# wired_bus_arbiter

Round-robin arbiter that sequences ownership of one shared resolved net (tri, wor or triand style) among NREQ requesters. It grants exactly one driver at a time and asserts that driver's output-enable. It inserts turnaround idle cycles between owners so two drivers never contend on the wire. A hold timeout forcibly revokes a requester that stalls the bus. The block sits beside the multi-driven net it controls, and its one-hot `oe` vector gates each driver's tristate/continuous assign.

## Interface
- NREQ, 4: number of requesters, 2..16.
- TURN_CYC, 1: idle cycles between owners, 1..4.
- HOLD_MAX, 8: maximum grant length in cycles before forced release, 2..255.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester bus request, level.
- last  input  NREQ  per-requester final-beat marker, only meaningful from the current owner.
- gnt  output  NREQ  one-hot grant, registered.
- oe  output  NREQ  one-hot drive enable, registered, identical to `gnt`.
- owner  output  $clog2(NREQ)  index of current or most recent owner.
- busy  output  1  high in GRANT and TURN.
- timeout  output  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, TURN.
- **IDLE:** if any `req` bit is set, pick the winner with round-robin from `ptr`. The search runs from `ptr` upward and wraps to bit 0. On the next edge go to GRANT, set gnt/oe to the winner's one-hot, load `owner`, clear `hold_cnt`, and set `ptr = (winner+1) mod NREQ`. If no request, stay in IDLE.
- **GRANT:** `hold_cnt` increments each cycle and saturates at HOLD_MAX.
- **GRANT release:** ownership ends at the edge where either condition holds:
  - `last[owner] & req[owner]`, or
  - `!req[owner]` (an early drop counts as a release).
  On release, clear gnt/oe and go to TURN with `turn_cnt = 0`.
- **GRANT timeout:** if `hold_cnt == HOLD_MAX-1` and no release, force release. Pulse `timeout` for one cycle, coincident with gnt falling, then go to TURN.
- **TURN:**
  - gnt and oe stay 0.
  - `turn_cnt` increments each cycle.
  - When `turn_cnt == TURN_CYC-1`, go to IDLE.
- `last`/`req` bits from non-owners are ignored during GRANT. Their requests stay pending and are not latched.
- Invariant: `$onehot0(gnt)` holds at all times, and `oe == gnt`.
- Reset (async assert, synchronous deassert handled externally):
  - state = IDLE, gnt = 0, oe = 0, owner = 0, busy = 0, timeout = 0, ptr = 0, counters = 0.
  - Reset asserted mid-GRANT drops `oe` immediately without waiting for a clock.

## Timing
- Request-to-grant latency: a request first seen in IDLE at edge t gives gnt high after edge t+1 (1 cycle).
- Release-to-next-grant: gnt falls at edge r, and the bus is idle for TURN_CYC cycles. The next arbitration happens in IDLE, so the earliest next gnt is at r+TURN_CYC+1.
- Back-to-back same requester: when the owner releases and re-requests, it competes normally. Because `ptr` has advanced, another pending requester wins first.
- Single-cycle grant: `last` asserted in the first GRANT cycle releases at the next edge, giving a grant length of 1.
- Maximum grant length is HOLD_MAX cycles, so `hold_cnt` needs 8 bits.
- Simultaneous `last` and timeout on the same edge: this is a normal release and `timeout` is not pulsed.
- `busy` is registered: high from the first GRANT cycle through the last TURN cycle.

## Structure
- Package `wbus_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT, TURN} wbus_state_t`
  - localparam limits for NREQ/TURN_CYC/HOLD_MAX range checks
  - a function returning the index width for a given NREQ
- Sub-module `rr_pick`: purely combinational. Inputs `req[NREQ]` and `ptr`; outputs `valid` and `idx`. It performs the rotate, priority-encode and un-rotate.
- The top holds the FSM, counters, `ptr` and the registered outputs. The state-parameter ranges are checked with elaboration-time assertions.

## Test plan
- **Reset then single request:** rst high 3 cycles, then low. Set `req = 4'b0100` at cycle 5 → gnt = 4'b0100 and owner = 2 at cycle 6; busy = 1; all outputs 0 during reset.
- **Round-robin fairness:** `req = 4'b1111` held, each owner asserts `last` in its 2nd grant cycle → grant order 0,1,2,3,0. Each grant lasts 2 cycles, separated by 1 TURN cycle and 1 IDLE cycle.
- **Timeout:** owner 1 holds `req` with no `last`, HOLD_MAX = 8 → gnt high exactly 8 cycles. `timeout` pulses once as gnt falls; `ptr` = 2 afterwards.
- **Early drop and ignored non-owners:**
  - Owner 3 drops `req` after 2 cycles while `last[0]` toggles → release after cycle 2 and no timeout.
  - Requester 0 is granted after the turnaround.
- **Async reset mid-grant:** rst asserted between edges during GRANT → gnt/oe = 0 before the next clk edge. After release, the first request is served from `ptr = 0`.
- **TURN_CYC = 3:** release at edge r → oe = 0 for cycles r..r+2, and the next gnt at r+4. Continuously assert `$onehot0(gnt)` and `oe == gnt`.

Source files
------------

// File: rtl/wbus_pkg.sv
// Shared types, parameter limits and width helper for the wired-bus arbiter.
package wbus_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, TURN} wbus_state_t;

   localparam int NREQ_MIN     = 2;
   localparam int NREQ_MAX     = 16;
   localparam int TURN_MIN     = 1;
   localparam int TURN_MAX     = 4;
   localparam int HOLD_MIN     = 2;
   localparam int HOLD_MAX_LIM = 255;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, find lowest set bit, un-rotate.
module rr_pick
   import wbus_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]            req,
   input  logic [idx_width(NREQ)-1:0] ptr,
   output logic                       valid,
   output logic [idx_width(NREQ)-1:0] idx
);

   localparam int IW = idx_width(NREQ);

   logic [NREQ-1:0] rot;
   logic [IW-1:0]   pos;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rot   = '0;
      valid = 1'b0;
      pos   = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[(i + int'(ptr)) % NREQ];
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            pos   = IW'(i);
         end
      end
      idx = IW'((int'(pos) + int'(ptr)) % NREQ);
   end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner sequencer for a shared resolved net: one-hot drive enable,
// turnaround gap between owners, and forced release after HOLD_MAX cycles.
module wired_bus_arbiter
   import wbus_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int TURN_CYC = 1,
   parameter int HOLD_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          last,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          oe,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     busy,
   output logic                     timeout
);

   localparam int IW = idx_width(NREQ);

   if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("wired_bus_arbiter: NREQ out of range");
   end
   if (TURN_CYC < TURN_MIN || TURN_CYC > TURN_MAX) begin : g_bad_turn
      $error("wired_bus_arbiter: TURN_CYC out of range");
   end
   if (HOLD_MAX < HOLD_MIN || HOLD_MAX > HOLD_MAX_LIM) begin : g_bad_hold
      $error("wired_bus_arbiter: HOLD_MAX out of range");
   end

   wbus_state_t   state;
   logic [IW-1:0] ptr;
   logic [7:0]    hold_cnt;
   logic [1:0]    turn_cnt;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          release_now;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // An early drop of req counts as a release just like last with req.
   assign release_now = !req[owner] || last[owner];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= GRANT;
                  gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                  owner    <= pick_idx;
                  hold_cnt <= '0;
                  ptr      <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt      <= '0;
                  state    <= TURN;
                  turn_cnt <= '0;
               end else if (hold_cnt == 8'(HOLD_MAX - 1)) begin
                  gnt      <= '0;
                  timeout  <= 1'b1;
                  state    <= TURN;
                  turn_cnt <= '0;
               end else if (hold_cnt != 8'(HOLD_MAX)) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            TURN: begin
               if (turn_cnt == 2'(TURN_CYC - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  turn_cnt <= turn_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign oe = gnt;

endmodule
